// File: rtl/bus_pkg.sv
// Shared definitions for the serial system bus.
// Used by both the master and slave ends.
package bus_pkg;

    localparam int BUS_ADDR_W          = 12;
    localparam int BUS_DATA_W          = 8;
    localparam int BUS_TIMEOUT_DEFAULT = 255;

    typedef enum logic [4:0] {
        S_IDLE  = 5'b00001,
        S_ADDR  = 5'b00010,
        S_WDATA = 5'b00100,
        S_RDATA = 5'b01000,
        S_RESP  = 5'b10000
    } bus_state_t;

endpackage

// File: rtl/master_rx_shift.sv
// Serial-to-parallel read-data capture for the master port.
// Tracks received bits and cycles since the last bit.
module master_rx_shift
    import bus_pkg::*;
#(
    parameter int ADDR_W  = BUS_ADDR_W,
    parameter int DATA_W  = BUS_DATA_W,
    parameter int TIMEOUT = BUS_TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              enable,
    input  logic              slave_valid,
    input  logic              rx_data,
    output logic [DATA_W-1:0] rdata,
    output logic              done,
    output logic              timeout
);

    localparam int CNT_W = $clog2(ADDR_W);
    localparam int IDX_W = $clog2(DATA_W);
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT);

    logic [CNT_W-1:0] bit_cnt;
    logic [TO_W-1:0]  to_cnt;
    logic             take;

    assign take    = enable & slave_valid;
    assign done    = take && (bit_cnt == LAST_BIT);
    assign timeout = enable && !slave_valid && (to_cnt == TO_MAX);

    // Capture valid bits; count idle cycles, both saturating.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata   <= '0;
            bit_cnt <= '0;
            to_cnt  <= '0;
        end else if (clear) begin
            rdata   <= '0;
            bit_cnt <= '0;
            to_cnt  <= '0;
        end else if (take) begin
            rdata[bit_cnt[IDX_W-1:0]] <= rx_data;
            to_cnt <= '0;
            if (bit_cnt != LAST_BIT) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
        end else if (enable && (to_cnt != TO_MAX)) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/master_port.sv
// Initiator end of the serial system bus.
// Serializes address/write data, deserializes read data.
module master_port
    import bus_pkg::*;
#(
    parameter int ADDR_W  = BUS_ADDR_W,
    parameter int DATA_W  = BUS_DATA_W,
    parameter int TIMEOUT = BUS_TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              read_en,
    output logic              write_en,
    output logic              master_valid,
    output logic              master_ready,
    input  logic              slave_ready,
    input  logic              slave_valid,
    output logic              tx_addr,
    output logic              tx_data,
    input  logic              rx_data
);

    localparam int CNT_W  = $clog2(ADDR_W);
    localparam int DIDX_W = $clog2(DATA_W);

    localparam logic [CNT_W-1:0] A_LAST = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0] D_LAST = CNT_W'(DATA_W - 1);

    bus_state_t        state;
    bus_state_t        state_nx;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              write_q;
    logic              err_q;
    logic              rdy_q;
    logic [CNT_W-1:0]  tx_cnt;
    logic              accept;
    logic              bit_xfer;
    logic              tx_last;
    logic [DATA_W-1:0] rx_rdata;
    logic              rx_done;
    logic              rx_timeout;

    assign accept   = (state == S_IDLE) & req_valid & rdy_q;
    assign bit_xfer = master_valid & slave_ready;
    assign tx_last  = ((state == S_ADDR) && (tx_cnt == A_LAST)) ||
                      ((state == S_WDATA) && (tx_cnt == D_LAST));

    assign req_ready    = rdy_q;
    assign master_valid = (state == S_ADDR) || (state == S_WDATA);
    assign master_ready = (state == S_RDATA);
    assign tx_addr      = (state == S_ADDR) && addr_q[tx_cnt];
    assign tx_data      = (state == S_WDATA) &&
                          wdata_q[tx_cnt[DIDX_W-1:0]];
    assign rsp_valid    = (state == S_RESP);
    assign rsp_err      = rsp_valid & err_q;
    assign rsp_rdata    = (rsp_valid && !err_q) ? rx_rdata : '0;

    master_rx_shift #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) u_rx (
        .clk         (clk),
        .reset       (reset),
        .clear       (accept),
        .enable      (master_ready),
        .slave_valid (slave_valid),
        .rx_data     (rx_data),
        .rdata       (rx_rdata),
        .done        (rx_done),
        .timeout     (rx_timeout)
    );

    // Next-state selection for the transaction sequencer.
    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (accept) state_nx = S_ADDR;
            end
            S_ADDR: begin
                if (bit_xfer && tx_last)
                    state_nx = write_q ? S_WDATA : S_RDATA;
            end
            S_WDATA: begin
                if (bit_xfer && tx_last) state_nx = S_RESP;
            end
            S_RDATA: begin
                if (rx_done || rx_timeout) state_nx = S_RESP;
            end
            S_RESP: begin
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // State register; ready is registered so it stays low in reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            rdy_q <= 1'b0;
        end else begin
            state <= state_nx;
            rdy_q <= (state_nx == S_IDLE);
        end
    end

    // Latch the request and hold the transaction type until RESP exits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            write_q  <= 1'b0;
            read_en  <= 1'b0;
            write_en <= 1'b0;
        end else if (accept) begin
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            write_q  <= req_write;
            read_en  <= ~req_write;
            write_en <= req_write;
        end else if (state == S_RESP) begin
            read_en  <= 1'b0;
            write_en <= 1'b0;
        end
    end

    // Transmit bit index: advances only on a completed handshake.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_cnt <= '0;
        end else if (accept) begin
            tx_cnt <= '0;
        end else if (bit_xfer) begin
            tx_cnt <= tx_last ? '0 : tx_cnt + 1'b1;
        end
    end

    // Read outcome: error only when the idle-cycle limit is hit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= 1'b0;
        end else if (state == S_RDATA) begin
            if (rx_done) err_q <= 1'b0;
            else if (rx_timeout) err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_master_port.sv
// Directed self-checking bench for master_port.
// Expected values come from hand-computed vectors.
module tb_master_port;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [11:0] req_addr = '0;
    logic [7:0]  req_wdata = '0;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_err;
    logic        read_en;
    logic        write_en;
    logic        master_valid;
    logic        master_ready;
    logic        slave_ready = 1'b0;
    logic        slave_valid = 1'b0;
    logic        tx_addr;
    logic        tx_data;
    logic        rx_data = 1'b0;
    logic [16:0] outs;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    master_port dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .read_en      (read_en),
        .write_en     (write_en),
        .master_valid (master_valid),
        .master_ready (master_ready),
        .slave_ready  (slave_ready),
        .slave_valid  (slave_valid),
        .tx_addr      (tx_addr),
        .tx_data      (tx_data),
        .rx_data      (rx_data)
    );

    assign outs = {req_ready, rsp_valid, rsp_rdata, rsp_err, read_en,
                   write_en, master_valid, master_ready, tx_addr, tx_data};

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Write; slave_ready dropped for stall_n cycles while bit stall_bit shows.
    task automatic run_write(input logic [11:0] a, input logic [7:0] d,
                             input int stall_bit, input int stall_n,
                             input int exp_rsp_cyc);
        logic [19:0] stream;
        int cyc;
        int bi;
        int stall_left;
        stream = {d, a};
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr = a;
        req_wdata = d;
        slave_ready = 1'b1;
        check("w_accept_rdy", req_ready, 1);
        tick();
        req_valid = 1'b0;
        cyc = 1;
        bi = 0;
        stall_left = stall_n;
        while (bi < 20 && cyc < 100) begin
            slave_ready = !(bi == stall_bit && stall_left > 0);
            check("w_busy", {req_ready, master_valid, read_en, write_en},
                  4'b0101);
            if (bi < 12)
                check("w_addr_line", {tx_addr, tx_data}, {stream[bi], 1'b0});
            else
                check("w_data_line", {tx_addr, tx_data}, {1'b0, stream[bi]});
            if (slave_ready) bi++;
            else stall_left--;
            tick();
            cyc++;
        end
        slave_ready = 1'b0;
        check("w_rsp_cycle", cyc, exp_rsp_cyc);
        check("w_rsp", {rsp_valid, rsp_err, write_en, master_valid}, 4'b1010);
        tick();
        check("w_after", {req_ready, rsp_valid, write_en}, 3'b100);
    endtask

    // Read; either return rv serially or never assert slave_valid.
    task automatic run_read(input logic [11:0] a, input logic [7:0] rv,
                            input logic [7:0] exp_d, input bit tmo);
        int cyc;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr = a;
        req_wdata = 8'hFF;
        slave_ready = 1'b1;
        check("r_accept_rdy", req_ready, 1);
        tick();
        req_valid = 1'b0;
        slave_valid = 1'b1;
        rx_data = 1'b1;
        for (int i = 0; i < 12; i++) begin
            check("r_addr_line", {master_valid, tx_addr}, {1'b1, a[i]});
            check("r_en", {read_en, write_en, req_ready}, 3'b100);
            tick();
        end
        check("r_rdata_entry", {master_ready, master_valid, tx_data},
              3'b100);
        if (!tmo) begin
            for (int i = 0; i < 8; i++) begin
                slave_valid = 1'b1;
                rx_data = rv[i];
                check("r_capture", {master_ready, rsp_valid}, 2'b10);
                tick();
            end
            slave_valid = 1'b0;
            rx_data = 1'b0;
            check("r_rsp", {rsp_valid, rsp_err, read_en}, 3'b101);
            check("r_rdata", rsp_rdata, exp_d);
        end else begin
            slave_valid = 1'b0;
            rx_data = 1'b1;
            cyc = 0;
            while (!rsp_valid && cyc < 400) begin
                tick();
                cyc++;
            end
            check("tmo_latency", cyc, 256);
            check("tmo_rsp", {rsp_valid, rsp_err, read_en}, 3'b111);
            check("tmo_rdata", rsp_rdata, exp_d);
        end
        tick();
        check("r_after", {req_ready, rsp_valid, read_en}, 3'b100);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        check("rst_outs", outs, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        check("rst_rdy_hold", req_ready, 0);
        tick();
        check("rst_rdy_rise", req_ready, 1);

        run_write(12'hA5C, 8'h3B, -1, 0, 21);
        tick();
        run_read(12'h001, 8'hC6, 8'hC6, 1'b0);
        tick();
        run_write(12'h3C7, 8'h96, 6, 3, 24);
        tick();
        run_read(12'h800, 8'h00, 8'h00, 1'b1);
        tick();

        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr = 12'h0F0;
        req_wdata = 8'h3B;
        slave_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        repeat (15) tick();
        check("mid_bit3", {master_valid, tx_addr, tx_data}, 3'b101);
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_outs", outs, 0);
        tick();
        check("mid_rst_hold", outs, 0);
        @(negedge clk);
        reset = 1'b1;
        check("mid_rdy_hold", {req_ready, rsp_valid}, 2'b00);
        tick();
        check("mid_rdy_rise", {req_ready, rsp_valid, write_en}, 3'b100);

        run_write(12'h5A3, 8'hE1, -1, 0, 21);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
